// File: rtl/dcache_data_arb_pkg.sv
// Shared dcache definitions used by the data-array arbiter.
// Contents:
//   Dcacheline_len / Dcache_way_num / Dcache_index_bits - default line geometry
//   arb_state_t  - refill sequencing states
//   lane_offset  - bit offset of a 32-bit word inside a packed multi-way row
//   merge_byte   - byte merge used when forwarding a same-cycle write into read data
package dcache_data_arb_pkg;

   localparam int unsigned Dcacheline_len    = 4;
   localparam int unsigned Dcache_way_num    = 2;
   localparam int unsigned Dcache_index_bits = 6;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_FILL = 1'b1
   } arb_state_t;

   // Ways sit side by side in the row: way w owns words [w*line_words +: line_words].
   function automatic int unsigned lane_offset(input int unsigned way,
                                               input int unsigned word,
                                               input int unsigned line_words);
      return (way * line_words + word) * 32;
   endfunction

   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/dcache_data_arb.sv
// Data-array port arbiter for the dcache. Owns the write port of a dual-port
// data RAM (instantiated by the parent) and shares it between line refills and
// CPU store hits; refills always win. The read port is passed straight through
// with a one-cycle response valid.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cpu_rd_valid/ready, cpu_rd_index    read request
//   cpu_rdata_valid, cpu_rdata          read response (1 cycle after accept)
//   cpu_wr_valid/ready, cpu_wr_index,
//   cpu_wr_strb, cpu_wr_data            store-hit row write
//   refill_valid/ready, refill_index,
//   refill_way, refill_word             refill beats (index/way taken on beat 0)
//   refill_done                         pulse the cycle after the last beat
//   bram_raddr/waddr/write_en/wdata     RAM control
//   bram_rdata                          RAM read data, 1-cycle, read-first
//
// Build option:
//   DCACHE_DATA_ARB_FWD_EN - a write accepted together with a read of the same
//   row is merged into that read's response instead of stalling the read.
module dcache_data_arb
   import dcache_data_arb_pkg::*;
#(
   parameter int unsigned LINE_WORDS = Dcacheline_len,
   parameter int unsigned WAY_NUM    = Dcache_way_num,
   parameter int unsigned INDEX_BITS = Dcache_index_bits,
   localparam int unsigned DW        = 32 * LINE_WORDS * WAY_NUM,
   localparam int unsigned BW        = DW / 8,
   localparam int unsigned WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
   localparam int unsigned CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_rd_valid,
   output logic                  cpu_rd_ready,
   input  logic [INDEX_BITS-1:0] cpu_rd_index,
   output logic                  cpu_rdata_valid,
   output logic [DW-1:0]         cpu_rdata,
   input  logic                  cpu_wr_valid,
   output logic                  cpu_wr_ready,
   input  logic [INDEX_BITS-1:0] cpu_wr_index,
   input  logic [BW-1:0]         cpu_wr_strb,
   input  logic [DW-1:0]         cpu_wr_data,
   input  logic                  refill_valid,
   output logic                  refill_ready,
   input  logic [INDEX_BITS-1:0] refill_index,
   input  logic [WAY_W-1:0]      refill_way,
   input  logic [31:0]           refill_word,
   output logic                  refill_done,
   output logic [INDEX_BITS-1:0] bram_raddr,
   output logic [INDEX_BITS-1:0] bram_waddr,
   output logic [BW-1:0]         bram_write_en,
   output logic [DW-1:0]         bram_wdata,
   input  logic [DW-1:0]         bram_rdata
);

   // state    | meaning
   // ARB_IDLE | no refill in progress; next refill beat is word 0
   // ARB_FILL | refill underway; row fill_index_q is locked against CPU access

   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
   logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
   logic [WAY_W-1:0]      fill_way_q, fill_way_d;
   logic                  refill_done_q, refill_done_d;
   logic                  rdata_valid_q;

   logic [INDEX_BITS-1:0] beat_index;
   logic [WAY_W-1:0]      beat_way;
   logic                  refill_acc, wr_acc, rd_acc;
   logic                  same_idx, fill_lock;

   assign refill_ready = 1'b1;
   assign refill_acc   = refill_valid & ~reset;

   // Index and way are only presented reliably on the first beat.
   assign beat_index = (state_q == ARB_FILL) ? fill_index_q : refill_index;
   assign beat_way   = (state_q == ARB_FILL) ? fill_way_q   : refill_way;

   assign cpu_wr_ready = ~refill_valid &
                         ~((state_q == ARB_FILL) && (cpu_wr_index == fill_index_q));
   assign wr_acc       = cpu_wr_valid & cpu_wr_ready & ~reset;

   always_comb begin
      bram_write_en = '0;
      bram_waddr    = cpu_wr_index;
      bram_wdata    = cpu_wr_data;
      if (refill_acc) begin
         bram_waddr = beat_index;
         // Word replicated across every lane; the strobe picks the one that lands.
         bram_wdata = {(LINE_WORDS * WAY_NUM){refill_word}};
         bram_write_en[lane_offset(32'(beat_way), 32'(word_cnt_q), LINE_WORDS) / 8 +: 4] = 4'hF;
      end else if (wr_acc) begin
         bram_write_en = cpu_wr_strb;
      end
   end

   assign same_idx  = (refill_acc | wr_acc) && (bram_waddr == cpu_rd_index);
   assign fill_lock = (state_q == ARB_FILL) && (cpu_rd_index == fill_index_q);

`ifdef DCACHE_DATA_ARB_FWD_EN
   assign cpu_rd_ready = ~fill_lock;
`else
   assign cpu_rd_ready = ~fill_lock & ~same_idx;
`endif

   assign rd_acc     = cpu_rd_valid & cpu_rd_ready & ~reset;
   assign bram_raddr = cpu_rd_index;

   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      fill_index_d  = fill_index_q;
      fill_way_d    = fill_way_q;
      refill_done_d = 1'b0;
      if (refill_acc) begin
         if (state_q == ARB_IDLE) begin
            fill_index_d = refill_index;
            fill_way_d   = refill_way;
         end
         if (word_cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            state_d       = ARB_IDLE;
            word_cnt_d    = '0;
            refill_done_d = 1'b1;
         end else begin
            state_d    = ARB_FILL;
            word_cnt_d = word_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         word_cnt_q    <= '0;
         fill_index_q  <= '0;
         fill_way_q    <= '0;
         refill_done_q <= 1'b0;
         rdata_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         fill_index_q  <= fill_index_d;
         fill_way_q    <= fill_way_d;
         refill_done_q <= refill_done_d;
         rdata_valid_q <= rd_acc;
      end
   end

   assign refill_done     = refill_done_q;
   assign cpu_rdata_valid = rdata_valid_q;

`ifdef DCACHE_DATA_ARB_FWD_EN
   logic [BW-1:0] fwd_strb_q;
   logic [DW-1:0] fwd_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_strb_q <= '0;
         fwd_data_q <= '0;
      end else begin
         fwd_strb_q <= (rd_acc && same_idx) ? bram_write_en : '0;
         fwd_data_q <= bram_wdata;
      end
   end

   // RAM is read-first, so the response carries pre-write bytes; patch them here.
   always_comb begin
      cpu_rdata = bram_rdata;
      for (int b = 0; b < int'(BW); b++) begin
         cpu_rdata[b*8 +: 8] = merge_byte(bram_rdata[b*8 +: 8], fwd_data_q[b*8 +: 8], fwd_strb_q[b]);
      end
   end
`else
   assign cpu_rdata = bram_rdata;
`endif

endmodule

// File: tb/tb_dcache_data_arb.sv
module tb_dcache_data_arb;
   import dcache_data_arb_pkg::*;

   localparam int IB = 6;
   localparam int DW = 256;
   localparam int BW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_rd_valid, cpu_rd_ready;
   logic [IB-1:0] cpu_rd_index;
   logic          cpu_rdata_valid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_wr_valid, cpu_wr_ready;
   logic [IB-1:0] cpu_wr_index;
   logic [BW-1:0] cpu_wr_strb;
   logic [DW-1:0] cpu_wr_data;
   logic          refill_valid, refill_ready;
   logic [IB-1:0] refill_index;
   logic [0:0]    refill_way;
   logic [31:0]   refill_word;
   logic          refill_done;
   logic [IB-1:0] bram_raddr, bram_waddr;
   logic [BW-1:0] bram_write_en;
   logic [DW-1:0] bram_wdata, bram_rdata;

   always #5 clk = ~clk;

   dcache_data_arb dut (
      .clk(clk), .reset(reset),
      .cpu_rd_valid(cpu_rd_valid), .cpu_rd_ready(cpu_rd_ready), .cpu_rd_index(cpu_rd_index),
      .cpu_rdata_valid(cpu_rdata_valid), .cpu_rdata(cpu_rdata),
      .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_index(cpu_wr_index),
      .cpu_wr_strb(cpu_wr_strb), .cpu_wr_data(cpu_wr_data),
      .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_index(refill_index),
      .refill_way(refill_way), .refill_word(refill_word), .refill_done(refill_done),
      .bram_raddr(bram_raddr), .bram_waddr(bram_waddr), .bram_write_en(bram_write_en),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   // Dual-port RAM: 1-cycle read latency, read-first on same-row write.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      bram_rdata <= mem[bram_raddr];
      for (int b = 0; b < BW; b++)
         if (bram_write_en[b]) mem[bram_waddr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
   end

   // Word w of row i starts as 0xD0000iww.
   function automatic logic [DW-1:0] init_row(input int i);
      logic [DW-1:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'hD000_0000 | 32'(i << 8) | 32'(w);
      return r;
   endfunction

   function automatic logic [DW-1:0] strb_mask(input logic [BW-1:0] s);
      logic [DW-1:0] m;
      for (int b = 0; b < BW; b++) m[b*8 +: 8] = {8{s[b]}};
      return m;
   endfunction

   typedef struct packed {
      logic [IB-1:0] addr;
      logic [BW-1:0] strb;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           exp_wr[$];
   logic [DW-1:0] exp_rd[$];
   int            exp_done[$];

   int n_pass = 0;
   int n_total = 0;

   task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every DUT output event is matched against the scoreboard queues.
   always @(negedge clk) begin
      wr_t           ew;
      logic [DW-1:0] m;
      if (cpu_rdata_valid === 1'b1) begin
         if (exp_rd.size() == 0) checki("rdata_unexpected", 1, 0);
         else checkw("rdata", cpu_rdata, exp_rd.pop_front());
      end
      if (|bram_write_en) begin
         if (exp_wr.size() == 0) checki("write_unexpected", 1, 0);
         else begin
            ew = exp_wr.pop_front();
            m  = strb_mask(ew.strb);
            checkw("wr_addr", DW'(bram_waddr), DW'(ew.addr));
            checkw("wr_strb", DW'(bram_write_en), DW'(ew.strb));
            checkw("wr_data", bram_wdata & m, ew.data & m);
         end
      end
      if (refill_done === 1'b1) begin
         if (exp_done.size() == 0) checki("done_unexpected", 1, 0);
         else void'(exp_done.pop_front());
      end
   end

   task automatic fin();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int addr, input logic [BW-1:0] s, input logic [DW-1:0] d);
      wr_t e;
      e.addr = IB'(addr);
      e.strb = s;
      e.data = d;
      exp_wr.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] r;
      logic [31:0] a [4];
      logic [31:0] bw [4];
      logic [31:0] cw [4];
      logic [31:0] dw [4];
      for (int k = 0; k < 4; k++) begin
         a[k]  = 32'hA000_00A0 + 32'(k);
         bw[k] = 32'hB000_00B0 + 32'(k);
         cw[k] = 32'hC000_00C0 + 32'(k);
         dw[k] = 32'hD1D1_00D0 + 32'(k);
      end
      for (int i = 0; i < 64; i++) mem[i] = init_row(i);

      reset = 1'b1;
      cpu_rd_valid = 0; cpu_rd_index = '0;
      cpu_wr_valid = 0; cpu_wr_index = '0; cpu_wr_strb = '0; cpu_wr_data = '0;
      refill_valid = 0; refill_index = '0; refill_way = '0; refill_word = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check1("rst_rdata_valid", cpu_rdata_valid, 1'b0);
      check1("rst_refill_done", refill_done, 1'b0);
      checkw("rst_write_en", DW'(bram_write_en), '0);
      check1("rst_refill_ready", refill_ready, 1'b1);
      check1("rst_wr_ready", cpu_wr_ready, 1'b1);
      check1("rst_rd_ready", cpu_rd_ready, 1'b1);
      fin();

      // Refill index 5, way 1, with locked/unlocked reads interleaved.
      refill_valid = 1; refill_index = 5; refill_way = 1; refill_word = a[0];
      push_wr(5, 32'h000F_0000, DW'(a[0]) << 128);
      @(negedge clk);
      check1("refill_ready_idle", refill_ready, 1'b1);
      fin();
      refill_word = a[1]; cpu_rd_valid = 1; cpu_rd_index = 5;
      push_wr(5, 32'h00F0_0000, DW'(a[1]) << 160);
      @(negedge clk);
      check1("lock_rd_idx5_b1", cpu_rd_ready, 1'b0);
      check1("refill_ready_fill", refill_ready, 1'b1);
      check1("wr_ready_refill", cpu_wr_ready, 1'b0);
      fin();
      refill_word = a[2]; cpu_rd_index = 6;
      push_wr(5, 32'h0F00_0000, DW'(a[2]) << 192);
      exp_rd.push_back(init_row(6));
      @(negedge clk);
      check1("rd_idx6_ready", cpu_rd_ready, 1'b1);
      fin();
      refill_word = a[3]; cpu_rd_index = 5;
      push_wr(5, 32'hF000_0000, DW'(a[3]) << 224);
      exp_done.push_back(1);
      @(negedge clk);
      check1("lock_rd_idx5_b3", cpu_rd_ready, 1'b0);
      check1("done_not_early", refill_done, 1'b0);
      fin();
      refill_valid = 0;
      @(negedge clk);
      check1("done_after_last", refill_done, 1'b1);
      check1("rd_idx5_unlocked", cpu_rd_ready, 1'b1);
      r = init_row(5);
      r[255:128] = {a[3], a[2], a[1], a[0]};
      exp_rd.push_back(r);
      fin();
      cpu_rd_valid = 0;
      @(negedge clk);
      check1("done_one_cycle", refill_done, 1'b0);
      fin();

      // Store to 9 collides with refill beat of index 10, way 0.
      refill_valid = 1; refill_index = 10; refill_way = 0; refill_word = bw[0];
      cpu_wr_valid = 1; cpu_wr_index = 9; cpu_wr_strb = 32'h0000_000F; cpu_wr_data = DW'(32'h1234_5678);
      push_wr(10, 32'h0000_000F, DW'(bw[0]));
      @(negedge clk);
      check1("wr_blocked_by_refill", cpu_wr_ready, 1'b0);
      fin();
      refill_valid = 0;
      push_wr(9, 32'h0000_000F, DW'(32'h1234_5678));
      @(negedge clk);
      check1("wr_after_refill", cpu_wr_ready, 1'b1);
      fin();
      cpu_wr_index = 10; cpu_wr_data = DW'(32'hDEAD_BEEF);
      @(negedge clk);
      check1("wr_locked_idx", cpu_wr_ready, 1'b0);
      fin();
      cpu_wr_valid = 0;
      // Later beats carry junk index/way; the latched values must be used.
      for (int k = 1; k < 4; k++) begin
         refill_valid = 1; refill_index = 0; refill_way = 1; refill_word = bw[k];
         push_wr(10, 32'h0000_000F << (4 * k), DW'(bw[k]) << (32 * k));
         if (k == 3) exp_done.push_back(1);
         fin();
      end
      refill_valid = 0;
      cpu_rd_valid = 1; cpu_rd_index = 9;
      r = init_row(9);
      r[31:0] = 32'h1234_5678;
      exp_rd.push_back(r);
      fin();
      cpu_rd_index = 10;
      r = init_row(10);
      r[127:0] = {bw[3], bw[2], bw[1], bw[0]};
      exp_rd.push_back(r);
      fin();

      // Same-cycle read and store to index 3.
      cpu_rd_index = 3;
      cpu_wr_valid = 1; cpu_wr_index = 3; cpu_wr_strb = 32'h0000_0001; cpu_wr_data = DW'(8'hAB);
      push_wr(3, 32'h0000_0001, DW'(8'hAB));
      r = init_row(3);
      r[7:0] = 8'hAB;
`ifdef DCACHE_DATA_ARB_FWD_EN
      exp_rd.push_back(r);
      @(negedge clk);
      check1("fwd_rd_ready", cpu_rd_ready, 1'b1);
      fin();
      cpu_wr_valid = 0;
`else
      @(negedge clk);
      check1("rd_blocked_same_idx", cpu_rd_ready, 1'b0);
      fin();
      cpu_wr_valid = 0;
      exp_rd.push_back(r);
      @(negedge clk);
      check1("rd_retry_ready", cpu_rd_ready, 1'b1);
      fin();
`endif
      cpu_rd_valid = 0;

      // Reset after two beats of index 20 abandons the line.
      refill_valid = 1; refill_index = 20; refill_way = 0;
      for (int k = 0; k < 2; k++) begin
         refill_word = cw[k];
         push_wr(20, 32'h0000_000F << (4 * k), DW'(cw[k]) << (32 * k));
         fin();
      end
      refill_word = cw[2];
      reset = 1;
      @(negedge clk);
      checkw("rst_mid_fill_wen", DW'(bram_write_en), '0);
      fin();
      reset = 0; refill_valid = 0;
      cpu_rd_valid = 1; cpu_rd_index = 20;
      r = init_row(20);
      r[63:0] = {cw[1], cw[0]};
      exp_rd.push_back(r);
      @(negedge clk);
      check1("rst_unlocks_idx20", cpu_rd_ready, 1'b1);
      check1("rst_no_done_0", refill_done, 1'b0);
      fin();
      cpu_rd_valid = 0;
      @(negedge clk);
      check1("rst_no_done_1", refill_done, 1'b0);
      fin();
      refill_index = 21; refill_way = 1;
      for (int k = 0; k < 4; k++) begin
         refill_valid = 1; refill_word = dw[k];
         push_wr(21, 32'h000F_0000 << (4 * k), DW'(dw[k]) << (128 + 32 * k));
         if (k == 3) exp_done.push_back(1);
         fin();
      end
      refill_valid = 0;
      cpu_rd_valid = 1; cpu_rd_index = 21;
      r = init_row(21);
      r[255:128] = {dw[3], dw[2], dw[1], dw[0]};
      exp_rd.push_back(r);
      fin();
      cpu_rd_valid = 0;
      repeat (3) fin();

      checki("rd_queue_drained", exp_rd.size(), 0);
      checki("wr_queue_drained", exp_wr.size(), 0);
      checki("done_queue_drained", exp_done.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
